// File: rtl/if0_pc_gen_if.sv
// Fetch-PC generator bundle: flush/pause/redirect/NLP inputs and PC-side outputs.
interface if0_pc_gen_if #(
  parameter int FETCH_WIDTH = 2,
  parameter int EPOCH_W     = 3
);
  logic                      flush;
  logic                      pause;
  logic                      bk_redirect_valid;
  logic [31:0]               bk_redirect_pc;
  logic                      if3_redirect;
  logic [31:0]               if3_redirect_pc;
  logic [FETCH_WIDTH-1:0]    nlp_valid;
  logic [FETCH_WIDTH-1:0]    nlp_taken;
  logic [32*FETCH_WIDTH-1:0] nlp_target;
  logic [31:0]               pc;
  logic [FETCH_WIDTH-1:0]    slot_mask;
  logic                      only_ds;
  logic [FETCH_WIDTH-1:0]    pred_slot_q;
  logic [31:0]               pred_target_q;
  logic [EPOCH_W-1:0]        epoch;
  logic                      bk_ready;

  modport master (
    output flush, pause, bk_redirect_valid, bk_redirect_pc, if3_redirect, if3_redirect_pc,
           nlp_valid, nlp_taken, nlp_target,
    input  pc, slot_mask, only_ds, pred_slot_q, pred_target_q, epoch, bk_ready
  );

  modport slave (
    input  flush, pause, bk_redirect_valid, bk_redirect_pc, if3_redirect, if3_redirect_pc,
           nlp_valid, nlp_taken, nlp_target,
    output pc, slot_mask, only_ds, pred_slot_q, pred_target_q, epoch, bk_ready
  );
endinterface

// File: rtl/if0_pc_gen.sv
// IF0 fetch-PC register: N-wide aligned groups, NLP-taken steering with MIPS delay slots,
// and a redirect epoch. One cycle from any redirect/prediction input to pc.
module if0_pc_gen #(
  parameter int          FETCH_WIDTH = 2,
  parameter logic [31:0] RESET_PC    = 32'hBFC0_0000,
  parameter int          EPOCH_W     = 3
) (
  input logic          clk,
  input logic          rst,
  if0_pc_gen_if.slave  bus
);
  localparam int          GB          = $clog2(FETCH_WIDTH * 4);
  localparam int          KW          = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
  localparam logic [31:0] GROUP_BYTES = 32'(FETCH_WIDTH * 4);

  logic [31:0]            pc_q;
  logic [31:0]            ds_addr_q;
  logic [31:0]            pred_target_q;
  logic                   only_ds_q;
  logic [FETCH_WIDTH-1:0] pred_slot_q;
  logic [EPOCH_W-1:0]     epoch_q;

  logic [KW-1:0]          off;
  logic [31:0]            npc;
  logic                   hit;
  logic [KW-1:0]          k;
  logic                   k_last;
  logic [31:0]            k_target;
  logic [FETCH_WIDTH-1:0] k_onehot;
  logic [FETCH_WIDTH-1:0] mask;

  generate
    if (FETCH_WIDTH > 1) begin : g_off
      assign off = pc_q[GB-1:2];
    end else begin : g_off_single
      assign off = 1'b0;
    end
  endgenerate

  assign npc = {pc_q[31:GB], {GB{1'b0}}} + GROUP_BYTES;

  // The delay-slot group ignores NLP hints entirely, so hit is gated by only_ds_q.
  always_comb begin
    hit      = 1'b0;
    k        = '0;
    mask     = '0;
    k_onehot = '0;
    for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
      if (!only_ds_q && i >= int'(off) && bus.nlp_valid[i] && bus.nlp_taken[i]) begin
        hit = 1'b1;
        k   = KW'(i);
      end
    end
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (only_ds_q) mask[i] = (i == int'(off));
      else           mask[i] = (i >= int'(off)) && !(hit && i > int'(k) + 1);
      k_onehot[i] = hit && (i == int'(k));
    end
    k_target = bus.nlp_target[32*int'(k) +: 32];
    k_last   = (int'(k) == FETCH_WIDTH - 1);
  end

  // only_ds_q doubles as the pending-delay-slot flag: they always set and clear together.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      only_ds_q     <= 1'b0;
      ds_addr_q     <= '0;
      pred_slot_q   <= '0;
      pred_target_q <= '0;
      epoch_q       <= '0;
    end else if (bus.flush || bus.bk_redirect_valid || bus.if3_redirect) begin
      pc_q          <= bus.flush             ? RESET_PC :
                       bus.bk_redirect_valid ? bus.bk_redirect_pc : bus.if3_redirect_pc;
      only_ds_q     <= 1'b0;
      pred_slot_q   <= '0;
      pred_target_q <= '0;
      epoch_q       <= epoch_q + EPOCH_W'(1);
    end else if (!bus.pause) begin
      pred_slot_q   <= k_onehot;
      pred_target_q <= hit ? k_target : 32'h0;
      if (only_ds_q) begin
        pc_q      <= ds_addr_q;
        only_ds_q <= 1'b0;
      end else if (hit && !k_last) begin
        pc_q <= k_target;
      end else if (hit) begin
        // Branch in the last slot: fetch the next group for its delay slot first.
        pc_q      <= npc;
        ds_addr_q <= k_target;
        only_ds_q <= 1'b1;
      end else begin
        pc_q <= npc;
      end
    end
  end

  assign bus.pc            = pc_q;
  assign bus.slot_mask     = mask;
  assign bus.only_ds       = only_ds_q;
  assign bus.pred_slot_q   = pred_slot_q;
  assign bus.pred_target_q = pred_target_q;
  assign bus.epoch         = epoch_q;
  assign bus.bk_ready      = 1'b1;
endmodule

// File: tb/tb_if0_pc_gen.sv
// Bench for if0_pc_gen at FETCH_WIDTH 2, 4 and 1 side by side, checked against a
// slot-level reference model; directed plan steps followed by random traffic.
module tb_if0_pc_gen;
  localparam logic [31:0] RPC = 32'hBFC0_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if0_pc_gen_if #(.FETCH_WIDTH(2), .EPOCH_W(3)) b0 ();
  if0_pc_gen_if #(.FETCH_WIDTH(4), .EPOCH_W(3)) b1 ();
  if0_pc_gen_if #(.FETCH_WIDTH(1), .EPOCH_W(3)) b2 ();

  if0_pc_gen #(.FETCH_WIDTH(2), .RESET_PC(RPC), .EPOCH_W(3)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  if0_pc_gen #(.FETCH_WIDTH(4), .RESET_PC(RPC), .EPOCH_W(3)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  if0_pc_gen #(.FETCH_WIDTH(1), .RESET_PC(RPC), .EPOCH_W(3)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));

  int n_checks = 0;
  int n_err    = 0;
  int fw_of[3] = '{2, 4, 1};

  logic        in_flush [3];
  logic        in_pause [3];
  logic        in_bk    [3];
  logic [31:0] in_bkpc  [3];
  logic        in_if3   [3];
  logic [31:0] in_if3pc [3];
  logic [7:0]  in_nv    [3];
  logic [7:0]  in_nt    [3];
  logic [31:0] in_tgt   [3][8];

  logic [31:0] m_pc [3];
  logic [31:0] m_dsa[3];
  logic [31:0] m_pt [3];
  logic [7:0]  m_ps [3];
  logic        m_ods[3];
  logic [2:0]  m_ep [3];

  always_comb begin
    b0.flush = in_flush[0]; b0.pause = in_pause[0];
    b0.bk_redirect_valid = in_bk[0]; b0.bk_redirect_pc = in_bkpc[0];
    b0.if3_redirect = in_if3[0]; b0.if3_redirect_pc = in_if3pc[0];
    b0.nlp_valid = in_nv[0][1:0]; b0.nlp_taken = in_nt[0][1:0];
    b0.nlp_target = {in_tgt[0][1], in_tgt[0][0]};
    b1.flush = in_flush[1]; b1.pause = in_pause[1];
    b1.bk_redirect_valid = in_bk[1]; b1.bk_redirect_pc = in_bkpc[1];
    b1.if3_redirect = in_if3[1]; b1.if3_redirect_pc = in_if3pc[1];
    b1.nlp_valid = in_nv[1][3:0]; b1.nlp_taken = in_nt[1][3:0];
    b1.nlp_target = {in_tgt[1][3], in_tgt[1][2], in_tgt[1][1], in_tgt[1][0]};
    b2.flush = in_flush[2]; b2.pause = in_pause[2];
    b2.bk_redirect_valid = in_bk[2]; b2.bk_redirect_pc = in_bkpc[2];
    b2.if3_redirect = in_if3[2]; b2.if3_redirect_pc = in_if3pc[2];
    b2.nlp_valid = in_nv[2][0]; b2.nlp_taken = in_nt[2][0];
    b2.nlp_target = in_tgt[2][0];
  end

  // Group arithmetic straight from the fetch-group definition: offset, first taken slot, mask.
  function automatic void model_eval(input int d, output logic [7:0] mask, output bit hit, output int k);
    int g   = fw_of[d] * 4;
    int off = int'((m_pc[d] % 32'(g)) >> 2);
    hit = 0; k = 0; mask = '0;
    if (!m_ods[d])
      for (int i = fw_of[d] - 1; i >= off; i--)
        if (in_nv[d][i] && in_nt[d][i]) begin hit = 1; k = i; end
    if (m_ods[d]) mask[off] = 1'b1;
    else
      for (int i = off; i < fw_of[d]; i++)
        if (!(hit && i > k + 1)) mask[i] = 1'b1;
  endfunction

  function automatic void model_step(input int d);
    logic [7:0]  mask;
    bit          hit;
    int          k;
    int          g   = fw_of[d] * 4;
    logic [31:0] npc = m_pc[d] - (m_pc[d] % 32'(g)) + 32'(g);
    model_eval(d, mask, hit, k);
    if (rst) begin
      m_pc[d] = RPC; m_ods[d] = 0; m_ps[d] = 0; m_pt[d] = 0; m_ep[d] = 0; m_dsa[d] = 0;
    end else if (in_flush[d] || in_bk[d] || in_if3[d]) begin
      m_pc[d]  = in_flush[d] ? RPC : (in_bk[d] ? in_bkpc[d] : in_if3pc[d]);
      m_ods[d] = 0; m_ps[d] = 0; m_pt[d] = 0;
      m_ep[d]  = m_ep[d] + 3'd1;
    end else if (in_pause[d]) begin
      // everything holds
    end else if (m_ods[d]) begin
      m_pc[d] = m_dsa[d]; m_ods[d] = 0; m_ps[d] = 0; m_pt[d] = 0;
    end else if (hit) begin
      m_ps[d] = 8'(1 << k);
      m_pt[d] = in_tgt[d][k];
      if (k < fw_of[d] - 1) m_pc[d] = in_tgt[d][k];
      else begin m_pc[d] = npc; m_dsa[d] = in_tgt[d][k]; m_ods[d] = 1; end
    end else begin
      m_pc[d] = npc; m_ps[d] = 0; m_pt[d] = 0;
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    logic [31:0] o_pc, o_pt;
    logic [7:0]  o_mask, o_ps, e_mask;
    logic        o_ods, o_rdy;
    logic [2:0]  o_ep;
    bit          h;
    int          k;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      case (d)
        0: begin o_pc = b0.pc; o_mask = 8'(b0.slot_mask); o_ods = b0.only_ds; o_ps = 8'(b0.pred_slot_q);
                 o_pt = b0.pred_target_q; o_ep = b0.epoch; o_rdy = b0.bk_ready; end
        1: begin o_pc = b1.pc; o_mask = 8'(b1.slot_mask); o_ods = b1.only_ds; o_ps = 8'(b1.pred_slot_q);
                 o_pt = b1.pred_target_q; o_ep = b1.epoch; o_rdy = b1.bk_ready; end
        default: begin o_pc = b2.pc; o_mask = 8'(b2.slot_mask); o_ods = b2.only_ds; o_ps = 8'(b2.pred_slot_q);
                 o_pt = b2.pred_target_q; o_ep = b2.epoch; o_rdy = b2.bk_ready; end
      endcase
      model_eval(d, e_mask, h, k);
      check($sformatf("d%0d_pc", d),        o_pc,        m_pc[d]);
      check($sformatf("d%0d_slot_mask", d), 32'(o_mask), 32'(e_mask));
      check($sformatf("d%0d_only_ds", d),   32'(o_ods),  32'(m_ods[d]));
      check($sformatf("d%0d_pred_slot", d), 32'(o_ps),   32'(m_ps[d]));
      check($sformatf("d%0d_pred_tgt", d),  o_pt,        m_pt[d]);
      check($sformatf("d%0d_epoch", d),     32'(o_ep),   32'(m_ep[d]));
      check($sformatf("d%0d_bk_ready", d),  32'(o_rdy),  32'd1);
    end
  endtask

  task automatic adv();
    for (int d = 0; d < 3; d++) model_step(d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int d = 0; d < 3; d++) begin
      in_flush[d] = 0; in_pause[d] = 0; in_bk[d] = 0; in_bkpc[d] = 0;
      in_if3[d] = 0; in_if3pc[d] = 0; in_nv[d] = 0; in_nt[d] = 0;
      for (int i = 0; i < 8; i++) in_tgt[d][i] = 32'h0;
    end
  endtask

  task automatic rand_inputs();
    for (int d = 0; d < 3; d++) begin
      in_flush[d] = ($urandom_range(39) == 0);
      in_pause[d] = ($urandom_range(5) == 0);
      in_bk[d]    = ($urandom_range(11) == 0);
      in_if3[d]   = ($urandom_range(11) == 0);
      in_bkpc[d]  = ($urandom_range(3) == 0) ? (32'hFFFF_FFE0 | ($urandom() & 32'h1C))
                                             : ($urandom() & 32'hFFFF_FFFC);
      in_if3pc[d] = $urandom() & 32'hFFFF_FFFC;
      in_nv[d]    = 8'($urandom());
      in_nt[d]    = 8'($urandom());
      for (int i = 0; i < 8; i++) in_tgt[d][i] = $urandom() & 32'hFFFF_FFFC;
    end
  endtask

  initial begin
    logic [31:0] e_pc;
    logic [2:0]  e_ep;
    idle();
    rst = 1'b1;
    adv();
    chk_all();                       // reset state visible while rst is still held
    adv();
    rst = 1'b0;

    // Sequential fetch from reset, FW=2
    for (int i = 0; i < 3; i++) begin
      chk_all();
      check("plan_seq_pc",   b0.pc, RPC + 32'(8 * i));
      check("plan_seq_mask", 32'(b0.slot_mask), 32'h3);
      check("plan_seq_epoch", 32'(b0.epoch), 32'h0);
      adv();
    end

    // FW=1: a taken hit always goes through the delay-slot route
    in_nv[2] = 8'h1; in_nt[2] = 8'h1; in_tgt[2][0] = 32'h7000;
    chk_all();
    check("plan_fw1_mask", 32'(b2.slot_mask), 32'h1);
    e_pc = m_pc[2] + 32'd4;
    adv(); idle();
    chk_all();
    check("plan_fw1_ds_pc", b2.pc, e_pc);
    check("plan_fw1_only_ds", 32'(b2.only_ds), 32'h1);
    adv();
    chk_all();
    check("plan_fw1_tgt_pc", b2.pc, 32'h7000);
    adv();

    // FW=4 taken at slot 2 from offset 1; FW=2 taken at last slot
    in_bk[0] = 1; in_bkpc[0] = 32'h1000;
    in_bk[1] = 1; in_bkpc[1] = 32'h1004;
    chk_all(); adv(); idle();
    in_nv[1] = 8'h4; in_nt[1] = 8'h4; in_tgt[1][2] = 32'h2000;
    in_nv[0] = 8'h2; in_nt[0] = 8'h2; in_tgt[0][1] = 32'h3000;
    chk_all();
    check("plan_fw4_mask", 32'(b1.slot_mask), 32'hE);
    adv(); idle();
    chk_all();
    check("plan_fw4_pc", b1.pc, 32'h2000);
    check("plan_fw4_pred_slot", 32'(b1.pred_slot_q), 32'h4);
    check("plan_ds_pc", b0.pc, 32'h1008);
    check("plan_ds_only", 32'(b0.only_ds), 32'h1);
    check("plan_ds_mask", 32'(b0.slot_mask), 32'h1);
    adv();
    chk_all();
    check("plan_ds_tgt", b0.pc, 32'h3000);
    adv();

    // Same delay slot with pause held two cycles
    in_bk[0] = 1; in_bkpc[0] = 32'h1000;
    chk_all(); adv(); idle();
    in_nv[0] = 8'h2; in_nt[0] = 8'h2; in_tgt[0][1] = 32'h3000;
    chk_all(); adv(); idle();
    for (int i = 0; i < 3; i++) begin
      in_pause[0] = (i < 2);
      chk_all();
      check("plan_pause_pc", b0.pc, 32'h1008);
      adv();
    end
    idle();
    chk_all();
    check("plan_pause_tgt", b0.pc, 32'h3000);
    adv();

    // Backend redirect beats IF3 redirect and a taken hint, and kills the pending delay slot
    in_bk[0] = 1; in_bkpc[0] = 32'h1000;
    chk_all(); adv(); idle();
    in_nv[0] = 8'h2; in_nt[0] = 8'h2; in_tgt[0][1] = 32'h3000;
    chk_all(); adv(); idle();
    in_bk[0] = 1; in_bkpc[0] = 32'h4000; in_if3[0] = 1; in_if3pc[0] = 32'h5000;
    in_nv[0] = 8'h3; in_nt[0] = 8'h3; in_tgt[0][0] = 32'h6000; in_tgt[0][1] = 32'h6100;
    e_ep = m_ep[0] + 3'd1;
    chk_all(); adv(); idle();
    chk_all();
    check("plan_prio_pc", b0.pc, 32'h4000);
    check("plan_prio_epoch", 32'(b0.epoch), 32'(e_ep));
    check("plan_prio_only_ds", 32'(b0.only_ds), 32'h0);
    adv();
    chk_all();
    check("plan_prio_seq", b0.pc, 32'h4008);
    adv();

    // Epoch wrap, flush, then reset while a delay slot is pending
    rst = 1; chk_all(); adv(); rst = 0;
    for (int i = 0; i < 9; i++) begin
      in_bk[0] = 1; in_bkpc[0] = 32'h100 + 32'(16 * i);
      chk_all(); adv();
    end
    idle();
    chk_all();
    check("plan_epoch_wrap", 32'(b0.epoch), 32'h1);
    in_flush[0] = 1;
    adv(); idle();
    chk_all();
    check("plan_flush_pc", b0.pc, RPC);
    check("plan_flush_epoch", 32'(b0.epoch), 32'h2);
    in_nv[0] = 8'h2; in_nt[0] = 8'h2; in_tgt[0][1] = 32'h9000;
    adv(); idle();
    chk_all();
    check("plan_rst_pre_only_ds", 32'(b0.only_ds), 32'h1);
    rst = 1;
    adv(); rst = 0;
    chk_all();
    check("plan_rst_pc", b0.pc, RPC);
    check("plan_rst_only_ds", 32'(b0.only_ds), 32'h0);
    check("plan_rst_epoch", 32'(b0.epoch), 32'h0);
    adv();

    // Random traffic against the model
    for (int c = 0; c < 800; c++) begin
      rand_inputs();
      rst = ($urandom_range(149) == 0);
      chk_all();
      adv();
    end
    rst = 0; idle();
    chk_all();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/if0_pc_gen.md
Name: if0_pc_gen

Overview:
- Parametrised fetch-PC generator for IF0. Holds the fetch PC and chooses the next PC from flush, backend redirect, IF3 redirect, a pending delay-slot jump, next-line-predictor (NLP) taken hints, pause, or the sequential path.
- Generalises the fixed two-wide IF0 PC register in four ways: N-wide aligned fetch groups, a per-slot valid mask, MIPS delay-slot handling at any slot position, and a redirect epoch counter so later stages can squash stale groups.
- Drives the PC to the NLP, the BPD and the ICache index.

Parameters:
- FETCH_WIDTH, 2, instructions per fetch group; a power of 2 from 1 to 8.
- RESET_PC, 32'hBFC0_0000, PC after reset and after flush.
- EPOCH_W, 3, width of the redirect epoch counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  pipeline flush; PC returns to RESET_PC.
- pause  in  1  stall from the control unit.
- bk_redirect_valid  in  1  backend redirect request.
- bk_redirect_pc  in  32  backend redirect target.
- if3_redirect  in  1  IF3 predecode redirect request.
- if3_redirect_pc  in  32  IF3 redirect target.
- nlp_valid  in  FETCH_WIDTH  per-slot NLP hit for the current group.
- nlp_taken  in  FETCH_WIDTH  per-slot NLP taken prediction.
- nlp_target  in  32*FETCH_WIDTH  per-slot target; slot i occupies bits [32i+31:32i].
- pc  out  32  current fetch PC (registered).
- slot_mask  out  FETCH_WIDTH  slots of the current group that should be issued (combinational).
- only_ds  out  1  current group carries only a delay slot (registered).
- pred_slot_q  out  FETCH_WIDTH  one-hot taken slot used for the previous group, or zero (registered, aligned to ICache output).
- pred_target_q  out  32  target paired with pred_slot_q (registered).
- epoch  out  EPOCH_W  redirect epoch (registered).
- bk_ready  out  1  constant 1.

Behaviour:
- Definitions:
  - G = FETCH_WIDTH*4.
  - off = pc[log2(G)-1:2], or 0 when FETCH_WIDTH=1.
  - base = pc with its low log2(G) bits cleared.
  - npc = base + G, with 32-bit wrap-around.
- Active slots are slots i with i >= off.
- k is the lowest active slot with nlp_valid[i] && nlp_taken[i]; "hit" means such a k exists. Slots below off are ignored.
- slot_mask:
  - If only_ds: only bit off is set.
  - Otherwise: bits off..last are set, and when hit, bits above k+1 are cleared.
  - rst, flush, any redirect, or pause in the same cycle do not affect slot_mask. The consumer qualifies it with those signals.
- Next-state priority, evaluated once per posedge clk:
  1. rst or flush: pc<=RESET_PC; only_ds<=0; ds_pending<=0. rst sets epoch<=0; flush alone sets epoch<=epoch+1.
  2. bk_redirect_valid: pc<=bk_redirect_pc; clear only_ds and ds_pending; epoch++.
  3. if3_redirect: same as step 2 using if3_redirect_pc.
  4. pause: hold pc, only_ds, ds_pending, ds_addr, epoch, pred_slot_q and pred_target_q. Redirects in steps 2 and 3 override pause.
  5. ds_pending: pc<=ds_addr; clear ds_pending and only_ds.
  6. hit with k < FETCH_WIDTH-1: the delay slot is inside the group. pc<=nlp_target[k]; only_ds<=0.
  7. hit with k == FETCH_WIDTH-1: the delay slot is in the next group. pc<=npc; ds_addr<=nlp_target[k]; ds_pending<=1; only_ds<=1.
  8. Otherwise: pc<=npc; only_ds<=0.
- ds_pending and only_ds are set together and cleared together; a single flop may implement both. While only_ds is 1, NLP inputs are ignored.
- pred_slot_q and pred_target_q:
  - In steps 5 to 8 they register the one-hot k and its target. When there is no hit, pred_slot_q<=0.
  - In steps 1 to 3 they clear to 0.
- epoch wraps modulo 2^EPOCH_W. Exactly one increment per redirect cycle.
- Reset values: pc=RESET_PC, only_ds=0, pred_slot_q=0, pred_target_q=0, epoch=0, ds_addr=0. slot_mask then follows from RESET_PC.
- Latency: one cycle from a redirect or prediction input to pc. No bubble is inserted.

Test Plan:
- Reset, FW=2, no hits, 3 cycles: pc goes BFC00000, BFC00008, BFC00010; slot_mask=2'b11 each cycle; epoch=0.
- FW=4, pc=0x1004, NLP taken at slot 2 (target 0x2000): slot_mask=4'b1110 in that cycle; next pc=0x2000; pred_slot_q=4'b0100.
- FW=2, pc=0x1000, NLP taken at slot 1 (target 0x3000):
  - next pc=0x1008 with only_ds=1 and slot_mask=2'b01.
  - one cycle later pc=0x3000.
  - repeat with pause held 2 cycles during only_ds: pc stays 0x1008 for those cycles, then 0x3000.
- bk_redirect_valid, if3_redirect and a taken NLP hint in the same cycle: pc takes bk_redirect_pc; epoch increments by exactly 1; ds_pending cleared even if it was set.
- EPOCH_W=3, 9 consecutive backend redirects: epoch ends at 1. A flush mid-run sets pc=BFC00000 and still increments epoch. rst asserted while ds_pending=1 gives pc=RESET_PC, only_ds=0 and epoch=0.
- FETCH_WIDTH=1: every taken hit takes step 7 (ds_pending route); slot_mask is always 1; pc increments by 4.
